// File: rtl/outport_pkg.sv
// Shared types and constants for the output-port peripheral.
// The OUTPORT_OVF_EN macro (see outport_unit) does not affect anything in this package.
package outport_pkg;

  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Width needed to hold an occupancy from 0 to depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/outport_fifo.sv
// Circular buffer with saturating occupancy counter used by outport_unit.
// Pushes into a full buffer are ignored unless a pop happens on the same edge.
module outport_fifo
  import outport_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                            Clock,
  input  logic                            Clear,
  input  logic                            push,
  input  logic [WIDTH-1:0]                push_data,
  input  logic                            pop,
  output logic [WIDTH-1:0]                head,
  output logic [count_width(DEPTH)-1:0]   count,
  output logic                            full,
  output logic                            empty
);

  localparam int CW = count_width(DEPTH);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge Clock) begin
    if (do_push)
      mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/outport_unit.sv
// Output-port peripheral: bus writes are buffered and streamed to a device over valid/ready.
// Define OUTPORT_OVF_EN to build the sticky overflow flag; otherwise ovf is tied low.
module outport_unit
  import outport_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                            Clock,
  input  logic                            Clear,
  input  logic                            OUTPORTin,
  input  logic [WIDTH-1:0]                BusMuxOut,
  output logic [WIDTH-1:0]                BusMuxInOutport,
  output logic [WIDTH-1:0]                port_data,
  output logic                            port_valid,
  input  logic                            port_ready,
  output logic                            full,
  output logic                            empty,
  output logic [count_width(DEPTH)-1:0]   count,
  output logic                            busy,
  output logic                            ovf
);

  state_t           state;
  logic             pop;
  logic             push;
  logic [WIDTH-1:0] head;

  // Pop uses the pre-edge empty flag, so a word just written is never bypassed.
  assign pop  = ~empty & ((state == IDLE) | port_ready);
  assign push = OUTPORTin & (~full | pop);
  assign busy = port_valid | ~empty;

  outport_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .Clock     (Clock),
    .Clear     (Clear),
    .push      (push),
    .push_data (BusMuxOut),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state      <= IDLE;
      port_valid <= 1'b0;
      port_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            port_data  <= head;
            port_valid <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          if (port_ready) begin
            if (pop) begin
              port_data <= head;
            end else begin
              port_valid <= 1'b0;
              state      <= IDLE;
            end
          end
        end
        default: begin
          port_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear)
      BusMuxInOutport <= '0;
    else if (OUTPORTin)
      BusMuxInOutport <= BusMuxOut;
  end

`ifdef OUTPORT_OVF_EN
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear)
      ovf <= 1'b0;
    else if (OUTPORTin && full && !pop)
      ovf <= 1'b1;
  end
`else
  assign ovf = 1'b0;
`endif

endmodule
